// File: rtl/multi_op_register_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// multi_op_register_pkg : op codes and FSM states for multi_op_register
// Revision: 1.0
// ------------------------------------------------------------------
package multi_op_register_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    LOAD = 3'd1,
    INC  = 3'd2,
    DEC  = 3'd3,
    ROR  = 3'd4,
    ROL  = 3'd5,
    SHR  = 3'd6,
    SHL  = 3'd7
  } op_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/multi_op_register_step.sv
`default_nettype none
// ------------------------------------------------------------------
// multi_op_register_step : one-bit shift/rotate step, purely combinational
// Revision: 1.0
// ------------------------------------------------------------------
module multi_op_register_step
  import multi_op_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] q_o,
  output logic             carry_o
);

  always_comb begin
    q_o     = q_i;
    carry_o = 1'b0;
    case (op_i)
      ROR: begin
        q_o     = {q_i[0], q_i[WIDTH-1:1]};
        carry_o = q_i[0];
      end
      ROL: begin
        q_o     = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        carry_o = q_i[WIDTH-1];
      end
      SHR: begin
        q_o     = {serial_i, q_i[WIDTH-1:1]};
        carry_o = q_i[0];
      end
      SHL: begin
        q_o     = {q_i[WIDTH-2:0], serial_i};
        carry_o = q_i[WIDTH-1];
      end
      default: begin
        q_o     = q_i;
        carry_o = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multi_op_register.sv
`default_nettype none
// ------------------------------------------------------------------
// multi_op_register : load/inc/dec/shift/rotate register, multi-bit shifts one bit per cycle
// Revision: 1.0
// ------------------------------------------------------------------
module multi_op_register
  import multi_op_register_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             op_valid,
  output logic             op_ready,
  input  op_t              op,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             carry,
  output logic             zero,
  output logic             done
);

  state_t           state_q, state_d;
  op_t              op_lat_q, op_lat_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  op_t              step_op;
  logic [WIDTH-1:0] step_q;
  logic             step_carry;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_diff;

  // The step unit serves both the acceptance edge and the STEP state.
  assign step_op = (state_q == STEP) ? op_lat_q : op;

  multi_op_register_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i     (step_op),
    .q_i      (q_q),
    .serial_i (serial_in),
    .q_o      (step_q),
    .carry_o  (step_carry)
  );

  assign inc_sum  = {1'b0, q_q} + (WIDTH+1)'(1);
  assign dec_diff = {1'b0, q_q} - (WIDTH+1)'(1);

  always_comb begin
    state_d  = state_q;
    op_lat_d = op_lat_q;
    rem_d    = rem_q;
    q_d      = q_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    if (clr) begin
      state_d = IDLE;
      q_d     = '0;
      carry_d = 1'b0;
    end else if (state_q == STEP) begin
      q_d     = step_q;
      carry_d = step_carry;
      rem_d   = rem_q - AMT_W'(1);
      if (rem_q == AMT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (op_valid) begin
      done_d = 1'b1;
      case (op)
        NOP: ;
        LOAD: begin
          q_d     = D;
          carry_d = 1'b0;
        end
        INC: {carry_d, q_d} = inc_sum;
        DEC: {carry_d, q_d} = dec_diff;
        default: begin
          if (amount != '0) begin
            q_d     = step_q;
            carry_d = step_carry;
            if (amount > AMT_W'(1)) begin
              state_d  = STEP;
              op_lat_d = op;
              rem_d    = amount - AMT_W'(1);
              done_d   = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_lat_q <= NOP;
      rem_q    <= '0;
      q_q      <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_lat_q <= op_lat_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

  assign op_ready = (state_q == IDLE);
  assign Q        = q_q;
  assign carry    = carry_q;
  assign zero     = (q_q == '0);
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_op_register.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_multi_op_register : directed self-checking bench for multi_op_register, WIDTH=8
// Revision: 1.0
// ------------------------------------------------------------------
module tb_multi_op_register;
  import multi_op_register_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       clr;
  logic       op_valid;
  logic       op_ready;
  op_t        op;
  logic [2:0] amount;
  logic       serial_in;
  logic [7:0] D;
  logic [7:0] Q;
  logic       carry;
  logic       zero;
  logic       done;

  int checks;
  int errors;

  multi_op_register #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .amount    (amount),
    .serial_in (serial_in),
    .D         (D),
    .Q         (Q),
    .carry     (carry),
    .zero      (zero),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_t o, input logic [7:0] d, input logic [2:0] amt, input logic s);
    op_valid  = 1'b1;
    op        = o;
    D         = d;
    amount    = amt;
    serial_in = s;
  endtask

  task automatic idle();
    op_valid = 1'b0;
    op       = NOP;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    clr       = 1'b0;
    op_valid  = 1'b0;
    op        = NOP;
    amount    = '0;
    serial_in = 1'b0;
    D         = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_q", Q, 8'h00);
    check("rst_carry", carry, 1'b0);
    check("rst_zero", zero, 1'b1);
    check("rst_ready", op_ready, 1'b1);
    check("rst_done", done, 1'b0);
    reset_n = 1'b1;

    // LOAD FF, INC wraps with carry, DEC borrows back
    issue(LOAD, 8'hFF, 3'd0, 1'b0); tick();
    check("load_ff_q", Q, 8'hFF);
    check("load_ff_done", done, 1'b1);
    idle(); tick();
    check("load_done_drop", done, 1'b0);
    issue(INC, 8'h00, 3'd0, 1'b0); tick();
    check("inc_q", Q, 8'h00);
    check("inc_carry", carry, 1'b1);
    check("inc_zero", zero, 1'b1);
    check("inc_done", done, 1'b1);
    idle(); tick();
    check("inc_done_drop", done, 1'b0);
    issue(DEC, 8'h00, 3'd0, 1'b0); tick();
    check("dec_q", Q, 8'hFF);
    check("dec_carry", carry, 1'b1);
    check("dec_zero", zero, 1'b0);

    // LOAD 81 then ROR by 3 (back-to-back with the DEC done cycle)
    issue(LOAD, 8'h81, 3'd0, 1'b0); tick();
    check("load_81_q", Q, 8'h81);
    issue(ROR, 8'h00, 3'd3, 1'b0); tick();
    check("ror1_q", Q, 8'hC0);
    check("ror1_carry", carry, 1'b1);
    check("ror1_ready", op_ready, 1'b0);
    check("ror1_done", done, 1'b0);
    idle(); tick();
    check("ror2_q", Q, 8'h60);
    check("ror2_ready", op_ready, 1'b0);
    check("ror2_done", done, 1'b0);
    tick();
    check("ror3_q", Q, 8'h30);
    check("ror3_carry", carry, 1'b0);
    check("ror3_ready", op_ready, 1'b1);
    check("ror3_done", done, 1'b1);
    tick();
    check("ror_done_drop", done, 1'b0);

    // SHL by 2 with serial fill of 1
    issue(LOAD, 8'h40, 3'd0, 1'b0); tick();
    issue(SHL, 8'h00, 3'd2, 1'b1); tick();
    check("shl1_q", Q, 8'h81);
    check("shl1_carry", carry, 1'b0);
    check("shl1_done", done, 1'b0);
    idle(); tick();
    check("shl2_q", Q, 8'h03);
    check("shl2_carry", carry, 1'b1);
    check("shl2_done", done, 1'b1);
    tick();
    check("shl_done_drop", done, 1'b0);

    // ROL by 7, LOAD attempted while busy, clr in the 3rd STEP cycle
    issue(LOAD, 8'h01, 3'd0, 1'b0); tick();
    issue(ROL, 8'h00, 3'd7, 1'b0); tick();
    check("rol1_q", Q, 8'h02);
    issue(LOAD, 8'hAA, 3'd0, 1'b0); tick();
    check("busy_load_ignored", Q, 8'h04);
    tick();
    check("rol3_q", Q, 8'h08);
    clr = 1'b1; tick();
    check("clr_q", Q, 8'h00);
    check("clr_carry", carry, 1'b0);
    check("clr_done", done, 1'b0);
    check("clr_ready", op_ready, 1'b1);
    // request together with clr in IDLE is not accepted
    issue(LOAD, 8'h55, 3'd0, 1'b0); tick();
    check("clr_req_q", Q, 8'h00);
    check("clr_req_done", done, 1'b0);
    clr = 1'b0; idle(); tick();
    check("post_clr_done", done, 1'b0);
    check("post_clr_q", Q, 8'h00);

    // amount=1 single-cycle SHR, then ROR amount=0 is a no-op
    issue(LOAD, 8'hB5, 3'd0, 1'b0); tick();
    issue(SHR, 8'h00, 3'd1, 1'b0); tick();
    check("shr1_q", Q, 8'h5A);
    check("shr1_carry", carry, 1'b1);
    check("shr1_ready", op_ready, 1'b1);
    check("shr1_done", done, 1'b1);
    issue(ROR, 8'h00, 3'd0, 1'b0); tick();
    check("ror0_q", Q, 8'h5A);
    check("ror0_carry", carry, 1'b1);
    check("ror0_done", done, 1'b1);
    check("ror0_ready", op_ready, 1'b1);
    idle(); tick();
    check("ror0_done_drop", done, 1'b0);

    // asynchronous reset in the middle of a multi-step ROR
    issue(LOAD, 8'h0F, 3'd0, 1'b0); tick();
    issue(ROR, 8'h00, 3'd5, 1'b0); tick();
    check("ror5_1_q", Q, 8'h87);
    idle(); tick();
    check("ror5_2_q", Q, 8'hC3);
    check("ror5_2_ready", op_ready, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_q", Q, 8'h00);
    check("arst_carry", carry, 1'b0);
    check("arst_zero", zero, 1'b1);
    check("arst_ready", op_ready, 1'b1);
    check("arst_done", done, 1'b0);
    #1 reset_n = 1'b1;
    tick();
    check("arst_hold_q", Q, 8'h00);
    check("arst_hold_done", done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
